// File: rtl/tt_um_addon_if.sv
// Pin bundle for the hypotenuse block: two operand buses in, result and
// the unused bidirectional pin controls out.
interface tt_um_addon_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_addon.sv
// Two-stage pipeline computing R = min(255, floor(sqrt(X*X + Y*Y))) on
// 8-bit unsigned operands; one new pair accepted every cycle.
module tt_um_addon (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  tt_um_addon_if.slave  bus
);

  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic [16:0] sum_sq;
  logic [8:0]  root;
  logic [7:0]  result_d;
  logic [7:0]  result_q;
  logic        unused_ena;

  // Restoring digit-by-digit square root; the loop unrolls into nine
  // compare/subtract stages, so the root is exact and never rounded up.
  function automatic logic [8:0] isqrt(input logic [16:0] s);
    logic [17:0] s_pad;
    logic [17:0] rem;
    logic [17:0] trial;
    logic [8:0]  r;
    s_pad = {1'b0, s};
    rem   = '0;
    r     = '0;
    for (int i = 8; i >= 0; i--) begin
      rem   = {rem[15:0], s_pad[2*i +: 2]};
      trial = {7'b0, r, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        r   = {r[7:0], 1'b1};
      end else begin
        r   = {r[7:0], 1'b0};
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= bus.ui_in;
      y_q <= bus.uio_in;
    end
  end

  always_comb begin
    sum_sq   = ({9'b0, x_q} * {9'b0, x_q}) + ({9'b0, y_q} * {9'b0, y_q});
    root     = isqrt(sum_sq);
    result_d = root[8] ? 8'hFF : root[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  // ena is a board-level select only and deliberately has no effect here.
  assign unused_ena  = ena;
  assign bus.uo_out  = result_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_addon.sv
// Self-checking bench for tt_um_addon: directed cases, latency, reset
// and a random sweep against an arithmetic hypotenuse model.
module tb_tt_um_addon;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;

  int checks = 0;
  int errors = 0;

  // Model of the pair currently held in the input stage.
  int p1_x = 0;
  int p1_y = 0;
  int exp_out = 0;

  tt_um_addon_if bus ();

  tt_um_addon dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Largest q with q*q <= x*x + y*y, clipped to 255.
  function automatic int hyp(input int x, input int y);
    int s;
    int q;
    s = x * x + y * y;
    q = 0;
    while ((q + 1) * (q + 1) <= s) q++;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Drive one pair (and reset level) for one clock edge, then check the
  // registered result against the model once the edge has settled.
  task automatic applyStimulus(input int x, input int y, input bit r);
    bus.ui_in  = x[7:0];
    bus.uio_in = y[7:0];
    rst_n      = r;
    @(posedge clk);
    #1;
    exp_out = r ? 0 : hyp(p1_x, p1_y);
    p1_x    = r ? 0 : x;
    p1_y    = r ? 0 : y;
    checkOutput("model", int'(bus.uo_out), exp_out);
  endtask

  task automatic holdPair(input int x, input int y, input int req, input string tag);
    for (int k = 0; k < 3; k++) applyStimulus(x, y, 1'b0);
    checkOutput(tag, int'(bus.uo_out), req);
  endtask

  initial begin
    bus.ui_in  = 8'd0;
    bus.uio_in = 8'd0;

    for (int k = 0; k < 3; k++) applyStimulus($urandom_range(255), $urandom_range(255), 1'b1);
    checkOutput("reset_uo_out", int'(bus.uo_out), 0);
    checkOutput("reset_uio_out", int'(bus.uio_out), 0);
    checkOutput("reset_uio_oe", int'(bus.uio_oe), 0);

    holdPair(20, 99, 101, "x20_y99");
    holdPair(6, 8, 10, "x6_y8");
    holdPair(15, 112, 113, "x15_y112");
    holdPair(50, 50, 70, "x50_y50");
    holdPair(255, 255, 255, "sat_255_255");
    holdPair(200, 150, 250, "x200_y150");
    holdPair(0, 0, 0, "zero");
    holdPair(0, 77, 77, "x0_y77");
    holdPair(112, 15, 113, "swap_x112_y15");

    // Back-to-back pairs: each answer must appear exactly two edges later.
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(3, 4, 1'b0);
    checkOutput("lat_not_early", int'(bus.uo_out), 0);
    applyStimulus(5, 12, 1'b0);
    checkOutput("lat_3_4", int'(bus.uo_out), 5);
    applyStimulus(8, 15, 1'b0);
    checkOutput("lat_5_12", int'(bus.uo_out), 13);
    applyStimulus(8, 15, 1'b0);
    checkOutput("lat_8_15", int'(bus.uo_out), 17);

    // Reset pulse while a pair is streaming discards the in-flight result.
    for (int k = 0; k < 3; k++) applyStimulus(20, 99, 1'b0);
    checkOutput("pre_reset", int'(bus.uo_out), 101);
    applyStimulus(20, 99, 1'b1);
    checkOutput("mid_reset", int'(bus.uo_out), 0);
    checkOutput("mid_reset_oe", int'(bus.uio_oe), 0);
    applyStimulus(20, 99, 1'b0);
    checkOutput("post_reset_1", int'(bus.uo_out), 0);
    applyStimulus(20, 99, 1'b0);
    checkOutput("post_reset_2", int'(bus.uo_out), 101);

    for (int n = 0; n < 1200; n++) begin
      applyStimulus($urandom_range(255), $urandom_range(255), 1'b0);
      if (n % 100 == 0) begin
        checkOutput("rand_uio_out", int'(bus.uio_out), 0);
        checkOutput("rand_uio_oe", int'(bus.uio_oe), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
